store_buffer: RTL and testbench

Posted-write buffer between the MEM stage's store path and a slow, handshaked data-memory bus. MEM-stage stores retire into a small in-order FIFO and drain to memory in the background through a req/ack handshake. MEM-stage loads are checked against pending entries: a full-word hit is forwarded, and a partial overlap raises a conflict so the hazard unit stalls until the entry drains.

---
 rtl/store_buffer.sv | 104 ++++++++++
 tb/tb_store_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order posted-write FIFO draining to a req/ack memory bus, with load forwarding/conflict lookup (SB_FORWARD_EN enables forwarding)
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [DATA_W/8-1:0]        st_be,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_conflict,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_be,
    input  logic                       mem_ack,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WA = ADDR_W - 2;
    localparam int BW = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [WA-1:0]     addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BW-1:0]     be_q   [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop, unused_lsbs;

    assign st_ready    = count_q != CW'(DEPTH);
    assign push        = st_valid && st_ready;
    assign pop         = state_q == BUSY && mem_ack;
    assign empty       = count_q == '0;
    assign count       = count_q;
    assign mem_req     = state_q == BUSY;
    assign mem_addr    = mem_req ? {addr_q[head_q], 2'b00} : '0;
    assign mem_wdata   = mem_req ? data_q[head_q] : '0;
    assign mem_be      = mem_req ? be_q[head_q] : '0;
    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    // Pointer/occupancy arithmetic and drain FSM: leave BUSY only when the last entry pops.
    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        state_d = state_q == IDLE ? (count_q != '0 ? BUSY : IDLE) : (count_d != '0 ? BUSY : IDLE);
    end

    // Scan oldest to newest so the newest word match decides the outcome.
    always_comb begin
        ld_hit      = 1'b0;
        ld_conflict = 1'b0;
        ld_data     = '0;
        idx         = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (ld_valid && CW'(i) < count_q && addr_q[idx] == ld_addr[ADDR_W-1:2]) begin
`ifdef SB_FORWARD_EN
                ld_hit      = &be_q[idx];
                ld_conflict = ~&be_q[idx];
                ld_data     = &be_q[idx] ? data_q[idx] : '0;
`else
                ld_conflict = 1'b1;
`endif
            end
        end
    end

    // Control state; reset abandons any transfer and discards every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr[ADDR_W-1:2];
            data_q[tail_q] <= st_data;
            be_q[tail_q]   <= st_be;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready, ld_valid, ld_hit, ld_conflict;
    logic        mem_req, mem_ack, empty;
    logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wdata;
    logic [3:0]  st_be, mem_be;
    logic [2:0]  count;
    int          passes = 0;
    int          checks = 0;

    store_buffer dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = b;
        step();
        st_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] a, input logic v);
        ld_addr  = a;
        ld_valid = v;
        #1;
    endtask

    task automatic drain_wait();
        int n = 0;
        mem_ack = 1'b1;
        while (count != 0 && n < 20) begin
            step();
            n++;
        end
        mem_ack = 1'b0;
        chk("drain_done", count, 0);
    endtask

    initial begin
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
        #3;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", st_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_hit", ld_hit, 0);
        chk("rst_conf", ld_conflict, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_ldata", ld_data, 0);
        @(negedge clk);
        reset = 1'b1;

        mem_ack = 1'b1;
        store(32'h100, 32'hDEADBEEF, 4'hF);
        chk("sd_count", count, 1);
        chk("sd_req_latency", mem_req, 0);
        step();
        chk("sd_req", mem_req, 1);
        chk("sd_addr", mem_addr, 32'h100);
        chk("sd_data", mem_wdata, 32'hDEADBEEF);
        chk("sd_be", mem_be, 4'hF);
        step();
        chk("sd_empty", empty, 1);
        chk("sd_req_off", mem_req, 0);
        mem_ack = 1'b0;

        for (int k = 0; k < 4; k++) store(32'h10 + 32'(4 * k), 32'hA000_0010 + 32'(4 * k), 4'hF);
        chk("full_count", count, 4);
        chk("full_ready", st_ready, 0);
        store(32'h20, 32'hBAD, 4'hF);
        chk("drop_count", count, 4);
        for (int k = 0; k < 4; k++) begin
            chk("ord_req", mem_req, 1);
            chk("ord_addr", mem_addr, 32'h10 + 32'(4 * k));
            chk("ord_data", mem_wdata, 32'hA000_0010 + 32'(4 * k));
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        chk("ord_count", count, 0);
        chk("ord_req_off", mem_req, 0);

        store(32'h200, 32'h12345678, 4'hF);
        store(32'h200, 32'hAABBCCDD, 4'hF);
        look(32'h200, 1'b1);
`ifdef SB_FORWARD_EN
        chk("fwd_hit", ld_hit, 1);
        chk("fwd_data", ld_data, 32'hAABBCCDD);
        chk("fwd_conf", ld_conflict, 0);
`else
        chk("nofwd_hit", ld_hit, 0);
        chk("nofwd_data", ld_data, 0);
        chk("nofwd_conf", ld_conflict, 1);
`endif
        look(32'h204, 1'b1);
        chk("miss_hit", ld_hit, 0);
        chk("miss_conf", ld_conflict, 0);
        look(32'h200, 1'b0);
        chk("novalid_hit", ld_hit, 0);
        chk("novalid_conf", ld_conflict, 0);
        drain_wait();
        look(32'h200, 1'b1);
        chk("drained_hit", ld_hit, 0);
        chk("drained_conf", ld_conflict, 0);

        st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h0000_1111; st_be = 4'b0011;
        look(32'h302, 1'b1);
        chk("same_cycle_conf", ld_conflict, 0);
        step();
        st_valid = 1'b0;
        #1;
        chk("part_conf", ld_conflict, 1);
        chk("part_hit", ld_hit, 0);
        drain_wait();
        chk("part_conf_clear", ld_conflict, 0);

        store(32'h400, 32'h11111111, 4'hF);
        store(32'h400, 32'h00000022, 4'h1);
        store(32'h500, 32'h00000033, 4'h1);
        store(32'h500, 32'h55667788, 4'hF);
        look(32'h400, 1'b1);
        chk("newest_part_conf", ld_conflict, 1);
        chk("newest_part_hit", ld_hit, 0);
        look(32'h500, 1'b1);
`ifdef SB_FORWARD_EN
        chk("newest_full_hit", ld_hit, 1);
        chk("newest_full_data", ld_data, 32'h55667788);
        chk("newest_full_conf", ld_conflict, 0);
`else
        chk("newest_full_hit", ld_hit, 0);
        chk("newest_full_conf", ld_conflict, 1);
`endif
        chk("four_count", count, 4);
        st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h66; st_be = 4'hF;
        mem_ack = 1'b1;
        step();
        st_valid = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("ackfull_count", count, 3);
        chk("ackfull_ready", st_ready, 1);
        chk("ackfull_addr", mem_addr, 32'h400);
        chk("ackfull_be", mem_be, 4'h1);
        chk("ackfull_data", mem_wdata, 32'h22);
        look(32'h600, 1'b1);
        chk("ackfull_dropped", ld_conflict, 0);
        drain_wait();
        ld_valid = 1'b0;

        store(32'h700, 32'h7, 4'hF);
        store(32'h704, 32'h8, 4'hF);
        chk("mid_req", mem_req, 1);
        chk("mid_count", count, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_req", mem_req, 0);
        chk("arst_ready", st_ready, 1);
        chk("arst_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_empty", empty, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
